uart_rx_byte: RTL and testbench

//   Complete UART receiver, 8N1, LSB first. Consumes the raw uart_rx pin,

---
 rtl/uart_rx_byte.sv | 139 +++++++++++++
 tb/tb_uart_rx_byte.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first: start-bit qualification, mid-bit sampling,
// stop-bit check and a valid/ready byte output with frame-error and overrun pulses.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CntW-1:0] CntBitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            rx_meta_q;
  logic            rx_s_q;

  // Two-flop synchroniser; reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A byte loaded later in this block overrides this clear.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          if (cnt_q == CntHalfEnd) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= StData;
              bit_idx_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (cnt_q == CntBitEnd) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s_q, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StStop: begin
          if (cnt_q == CntBitEnd) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg_q;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state_q <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        // Hold off until the line returns high so a break is not read as a start.
        StWaitHigh: begin
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          bit_idx_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: serial frames driven on uart_rx, received
// bytes checked against a queue of expected values at each handshake.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_mis = 0;
  int hs_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vhi_cnt = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  int b_hs, b_fe, b_ov, b_vhi, lat;

  always #1 clk = ~clk;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx  = 1'b0;
    fall_cyc = cyc;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      step(CPB);
    end
    uart_rx = stop;
    step(CPB);
  endtask

  task automatic snap();
    b_hs  = hs_cnt;
    b_fe  = fe_cnt;
    b_ov  = ov_cnt;
    b_vhi = vhi_cnt;
  endtask

  // Monitor samples midway between the driving negedge and the next posedge.
  always begin
    @(negedge clk);
    #0.5;
    if (!rst) begin
      if (rx_valid) vhi_cnt++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        n_cmp++;
        assert (exp_q.size() != 0)
        else begin
          n_mis++;
          $error("FAIL sb_unexpected: observed byte %0h expected none", rx_data);
        end
        if (exp_q.size() != 0) check("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    step(1);
    // Reset state
    rst = 1'b1;
    step(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    step(4);
    check("idle_valid", rx_valid, 0);

    // 1: single byte with ready high
    rx_ready = 1'b1;
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    step(4);
    check("t1_hs", hs_cnt - b_hs, 1);
    check("t1_valid_cycles", vhi_cnt - b_vhi, 1);
    check("t1_ferr", fe_cnt - b_fe, 0);
    check("t1_ovr", ov_cnt - b_ov, 0);
    check("t1_data", rx_data, 8'hA5);
    lat = rise_cyc - fall_cyc;
    n_cmp++;
    assert (lat >= 78 && lat <= 80)
    else begin
      n_mis++;
      $error("FAIL t1_latency: observed %0d expected 79 (+-1)", lat);
    end

    // 2: short glitch rejected, then a good frame
    snap();
    uart_rx = 1'b0;
    step(2);
    uart_rx = 1'b1;
    step(20);
    check("t2_glitch_hs", hs_cnt - b_hs, 0);
    check("t2_glitch_ferr", fe_cnt - b_fe, 0);
    check("t2_glitch_valid", rx_valid, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    step(4);
    check("t2_hs", hs_cnt - b_hs, 1);
    check("t2_data", rx_data, 8'h3C);

    // 3: bad stop bit with line held low
    snap();
    send_frame(8'h5A, 1'b0);
    step(20);
    check("t3_ferr", fe_cnt - b_fe, 1);
    check("t3_hs", hs_cnt - b_hs, 0);
    check("t3_valid", rx_valid, 0);
    uart_rx = 1'b1;
    step(10);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    step(4);
    check("t3_hs_after", hs_cnt - b_hs, 1);
    check("t3_ferr_after", fe_cnt - b_fe, 1);
    check("t3_data", rx_data, 8'h3C);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(4);
    check("t4_ovr", ov_cnt - b_ov, 1);
    check("t4_valid_held", rx_valid, 1);
    check("t4_data_kept", rx_data, 8'h11);
    check("t4_hs_stalled", hs_cnt - b_hs, 0);
    rx_ready = 1'b1;
    step(3);
    check("t4_hs", hs_cnt - b_hs, 1);
    check("t4_valid_clr", rx_valid, 0);

    // 5: reset during data bit 3
    snap();
    uart_rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      step(CPB);
    end
    uart_rx = 1'b0;
    step(CPB / 2);
    rst = 1'b1;
    uart_rx = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_valid", rx_valid, 0);
    check("t5_data", rx_data, 0);
    check("t5_ferr", frame_err, 0);
    check("t5_ovr", overrun, 0);
    step(20);
    check("t5_no_hs", hs_cnt - b_hs, 0);
    check("t5_no_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    step(4);
    check("t5_hs", hs_cnt - b_hs, 1);
    check("t5_rx", rx_data, 8'hC3);

    // 6: back-to-back frames
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    step(4);
    check("t6_hs", hs_cnt - b_hs, 3);
    check("t6_valid_cycles", vhi_cnt - b_vhi, 3);
    check("t6_ferr", fe_cnt - b_fe, 0);
    check("t6_ovr", ov_cnt - b_ov, 0);
    check("t6_data", rx_data, 8'h81);

    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
